// File: rtl/jtkiwi_tiledraw.sv
// jtkiwi_tiledraw: responder side of the tile draw handshake.
// Accepts one 16-pixel tile row request, fetches two 32-bit ROM words
// (8 pixels at 4bpp each), and writes the opaque pixels to the line buffer.
// Optional build macro JTKIWI_TILEDRAW_XCLIP_EN: suppress writes whose line
// buffer address is 384 or above (counter and timing are unaffected).
module jtkiwi_tiledraw #(
    parameter int PXL_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        draw,
    output logic        busy,
    input  logic [15:0] code,
    input  logic [15:0] attr,
    input  logic [8:0]  xpos,
    input  logic [3:0]  ysub,
    input  logic        flip,
    output logic [17:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [31:0] rom_data,
    output logic [8:0]  buf_addr,
    output logic        buf_we,
    output logic [8:0]  buf_din
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAW  = 2'd3
    } state_t;

    // Last sub-cycle of a pixel slot (PXL_CYC is 1 or 2)
    localparam logic [0:0] CYC_LAST = 1'(PXL_CYC - 1);

    state_t      state_r, state_nx_s;
    logic [12:0] code_r;
    logic [4:0]  pal_r;
    logic        hf_r;
    logic [3:0]  row_r;
    logic        half_r;
    logic        second_r;
    logic [31:0] data_r;
    logic [2:0]  pix_r;
    logic [0:0]  cyc_r;
    logic [8:0]  xcnt_r;

    logic        hf_in_s, vf_in_s;
    logic [3:0]  row_in_s;
    logic        slot_end_s;
    logic [2:0]  nib_idx_s;
    logic [31:0] data_sh_s;
    logic [3:0]  nib_s;
    logic        vis_s;
    logic        unused_s;

    logic        busy_s, rom_cs_s, buf_we_s;
    logic [17:0] rom_addr_s;
    logic [8:0]  buf_addr_s, buf_din_s;

    // Flip decode at request time; global flip inverts both tile flips
    assign hf_in_s    = code[15] ^ flip;
    assign vf_in_s    = code[14] ^ flip;
    assign row_in_s   = vf_in_s ? ~ysub : ysub;
    assign slot_end_s = (cyc_r == CYC_LAST);
    // Horizontal flip reverses nibble order within each ROM word
    assign nib_idx_s  = hf_r ? (3'd7 - pix_r) : pix_r;
    assign data_sh_s  = data_r >> {nib_idx_s, 2'b00};
    assign nib_s      = data_sh_s[3:0];
    assign unused_s   = ^{attr[10:0], code[13]};

`ifdef JTKIWI_TILEDRAW_XCLIP_EN
    assign vis_s = (xcnt_r < 9'd384);
`else
    assign vis_s = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: WAIT is a single settle cycle, FETCH stalls on rom_ok
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (draw) state_nx_s = ST_WAIT;
                else      state_nx_s = ST_IDLE;
            end
            ST_WAIT: state_nx_s = ST_FETCH;
            ST_FETCH: begin
                if (rom_ok) state_nx_s = ST_DRAW;
                else        state_nx_s = ST_FETCH;
            end
            ST_DRAW: begin
                if (slot_end_s && (pix_r == 3'd7)) begin
                    if (second_r) state_nx_s = ST_IDLE;
                    else          state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_DRAW;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered interface outputs
    always_comb begin
        busy_s     = (state_nx_s != ST_IDLE);
        rom_cs_s   = (state_nx_s == ST_WAIT) || (state_nx_s == ST_FETCH);
        rom_addr_s = rom_addr;
        buf_we_s   = 1'b0;
        buf_addr_s = buf_addr;
        buf_din_s  = buf_din;
        case (state_r)
            ST_IDLE: begin
                if (draw) rom_addr_s = {code[12:0], hf_in_s, row_in_s};
                else      rom_addr_s = rom_addr;
            end
            ST_DRAW: begin
                if (slot_end_s) begin
                    buf_we_s   = (nib_s != 4'd0) && vis_s;
                    buf_addr_s = xcnt_r;
                    buf_din_s  = {pal_r, nib_s};
                    if ((pix_r == 3'd7) && !second_r) rom_addr_s = {code_r, ~half_r, row_r};
                    else                              rom_addr_s = rom_addr;
                end else begin
                    buf_we_s = 1'b0;
                end
            end
            default: begin
                rom_addr_s = rom_addr;
            end
        endcase
    end

    // Registered interface outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            rom_cs   <= 1'b0;
            rom_addr <= 18'd0;
            buf_we   <= 1'b0;
            buf_addr <= 9'd0;
            buf_din  <= 9'd0;
        end else begin
            busy     <= busy_s;
            rom_cs   <= rom_cs_s;
            rom_addr <= rom_addr_s;
            buf_we   <= buf_we_s;
            buf_addr <= buf_addr_s;
            buf_din  <= buf_din_s;
        end
    end

    // Request latch, ROM data capture and pixel/address counters
    always_ff @(posedge clk) begin
        if (rst) begin
            code_r   <= 13'd0;
            pal_r    <= 5'd0;
            hf_r     <= 1'b0;
            row_r    <= 4'd0;
            half_r   <= 1'b0;
            second_r <= 1'b0;
            data_r   <= 32'd0;
            pix_r    <= 3'd0;
            cyc_r    <= 1'b0;
            xcnt_r   <= 9'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (draw) begin
                        code_r   <= code[12:0];
                        pal_r    <= attr[15:11];
                        hf_r     <= hf_in_s;
                        row_r    <= row_in_s;
                        half_r   <= hf_in_s;
                        second_r <= 1'b0;
                        xcnt_r   <= xpos;
                        pix_r    <= 3'd0;
                        cyc_r    <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (rom_ok) begin
                        data_r <= rom_data;
                        pix_r  <= 3'd0;
                        cyc_r  <= 1'b0;
                    end
                end
                ST_DRAW: begin
                    if (slot_end_s) begin
                        cyc_r  <= 1'b0;
                        pix_r  <= pix_r + 3'd1;
                        xcnt_r <= xcnt_r + 9'd1;
                        if (pix_r == 3'd7) begin
                            half_r   <= ~half_r;
                            second_r <= 1'b1;
                        end
                    end else begin
                        cyc_r <= cyc_r + 1'b1;
                    end
                end
                default: begin
                    data_r <= data_r;
                end
            endcase
        end
    end

endmodule
